// File: rtl/disp_scan.sv
// Multiplexed 7-segment scan controller: one shared hex decoder, one-hot anode scan with a
// per-slot guard interval, and a pending/active shadow so new values switch only at frame edges.
module disp_scan #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 50000,
    parameter int unsigned GUARD  = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0]   act_data_q, act_data_d;
    logic [DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [4*DIGITS-1:0]   pend_data_q, pend_data_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                  pend_v_q, pend_v_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  fs_q, fs_d;

    logic                  slot_end;
    logic                  frame_end;

    function automatic logic [6:0] dek7seg(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign slot_end  = (cnt_q == CntLast);
    assign frame_end = slot_end && (idx_q == IdxLast);

    // Scan counters and shadow registers
    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_v_d    = pend_v_q;

        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end

        if (load) begin
            pend_data_d = data_in;
            pend_dp_d   = dp_in;
            pend_v_d    = 1'b1;
        end

        // A load landing on the boundary cycle bypasses pending straight into active.
        if (frame_end) begin
            if (load) begin
                act_data_d = data_in;
                act_dp_d   = dp_in;
                pend_v_d   = 1'b0;
            end else if (pend_v_q) begin
                act_data_d = pend_data_q;
                act_dp_d   = pend_dp_q;
                pend_v_d   = 1'b0;
            end
        end
    end

    // Registered outputs computed from the current slot state
    always_comb begin
        logic       upper_zero;
        logic       suppress;
        logic [3:0] nib;

        upper_zero = 1'b1;
        suppress   = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (act_data_q[4*i +: 4] == 4'h0);
            if ((IdxW'(i) == idx_q) && (i != 0)) begin
                suppress = upper_zero && lz_en;
            end
        end

        nib   = act_data_q[4*idx_q +: 4];
        seg_d = (blank_mask[idx_q] || suppress) ? 7'h00 : dek7seg(nib);
        dp_d  = act_dp_q[idx_q] & ~blank_mask[idx_q];

        an_d = '0;
        if (32'(cnt_q) >= GUARD) begin
            an_d[idx_q] = 1'b1;
        end

        fs_d = (cnt_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_v_q    <= 1'b0;
            seg_q       <= '0;
            dp_q        <= 1'b0;
            an_q        <= '0;
            fs_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_v_q    <= pend_v_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            fs_q        <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_disp_scan.sv
// Bench for disp_scan: directed scenarios plus random traffic, checked every cycle against a
// frame-position model of the display.
module tb_disp_scan;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int GUARD  = 2;
    localparam int FRAME  = DIGITS * DIV;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_mask = '0;
    logic        lz_en = 1'b0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    // Model: position within the frame plus the active/pending display contents
    int          m_pos;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_dp, m_pend_dp;
    bit          m_pv;

    disp_scan #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .blank_mask  (blank_mask),
        .lz_en       (lz_en),
        .load        (load),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos     = 0;
        m_act     = '0;
        m_pend    = '0;
        m_act_dp  = '0;
        m_pend_dp = '0;
        m_pv      = 1'b0;
    endtask

    task automatic tick();
        int         i, c;
        logic [3:0] nib;
        logic [6:0] e_seg;
        logic [3:0] e_an;
        logic       e_dp, e_fs, supp;

        i    = m_pos / DIV;
        c    = m_pos % DIV;
        e_fs = (m_pos == 0);
        e_an = (c < GUARD) ? 4'b0000 : 4'(1 << i);
        nib  = 4'((m_act >> (4 * i)) & 16'hF);
        supp = lz_en && (i > 0) && ((m_act >> (4 * i)) == 16'h0);
        e_seg = (blank_mask[i] || supp) ? 7'h00 : SEG_TBL[int'(nib)];
        e_dp  = m_act_dp[i] & ~blank_mask[i];

        if (m_pos == FRAME - 1 && load) begin
            m_act    = data_in;
            m_act_dp = dp_in;
            m_pv     = 1'b0;
        end else begin
            if (m_pos == FRAME - 1 && m_pv) begin
                m_act    = m_pend;
                m_act_dp = m_pend_dp;
                m_pv     = 1'b0;
            end
            if (load) begin
                m_pend    = data_in;
                m_pend_dp = dp_in;
                m_pv      = 1'b1;
            end
        end
        m_pos = (m_pos + 1) % FRAME;

        @(posedge clk);
        #1;
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("an", 32'(an), 32'(e_an));
        check("frame_start", 32'(frame_start), 32'(e_fs));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            check("rst_seg", 32'(seg), 32'h0);
            check("rst_dp", 32'(dp), 32'h0);
            check("rst_an", 32'(an), 32'h0);
            check("rst_fs", 32'(frame_start), 32'h0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        data_in = d;
        dp_in   = p;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic goto_pos(input int p);
        for (int k = 0; k < FRAME && m_pos != p; k++) tick();
        check("goto_pos", 32'(m_pos), 32'(p));
    endtask

    initial begin
        model_reset();
        #3;
        do_reset();

        // Reset release, scan order and frame period
        run(3 * FRAME + 6);

        // Mid-frame load is held until the next frame
        goto_pos(13);
        pulse_load(16'h1234, 4'b0000);
        run(2 * FRAME);

        // Load on the boundary cycle goes straight to active
        goto_pos(FRAME - 1);
        pulse_load(16'hABCD, 4'b0000);
        run(2 * FRAME);

        // Leading-zero suppression, dp kept on a suppressed digit
        lz_en = 1'b1;
        goto_pos(5);
        pulse_load(16'h0020, 4'b1000);
        run(2 * FRAME);
        lz_en = 1'b0;
        run(FRAME + 3);

        // Blank mask hides digits 0 and 2 while anodes still cycle
        goto_pos(9);
        pulse_load(16'h5A3C, 4'b1111);
        run(FRAME);
        blank_mask = 4'b0101;
        run(FRAME + 5);
        blank_mask = 4'b0000;
        run(4);

        // Reset during slot 2 discards a pending load
        goto_pos(3);
        pulse_load(16'h9876, 4'b0110);
        goto_pos(2 * DIV + 4);
        #2;
        do_reset();
        run(2 * FRAME);

        // Random traffic
        for (int k = 0; k < 1200; k++) begin
            load    = ($urandom_range(0, 6) == 0);
            data_in = 16'($urandom);
            dp_in   = 4'($urandom);
            if ($urandom_range(0, 40) == 0) blank_mask = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 30) == 0) lz_en = 1'($urandom);
            // Bias toward values with leading zeros so suppression gets exercised
            if ($urandom_range(0, 2) == 0) data_in = data_in >> (4 * $urandom_range(1, 3));
            tick();
        end
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
